// File: rtl/spi_cfg_hub_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_cfg_hub_if
// Purpose  : SPI pin bundle between an MCU SPI master and the spi_cfg_hub
//            slave.
// Signals  : ncs_spi  - chip select, active low (master -> slave)
//            sck_spi  - SPI clock, mode 0   (master -> slave)
//            mosi_spi - data, MSB first     (master -> slave)
//            miso_spi - data, MSB first     (slave  -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface spi_cfg_hub_if;
  logic ncs_spi;
  logic sck_spi;
  logic mosi_spi;
  logic miso_spi;

  modport master (
    output ncs_spi,
    output sck_spi,
    output mosi_spi,
    input  miso_spi
  );

  modport slave (
    input  ncs_spi,
    input  sck_spi,
    input  mosi_spi,
    output miso_spi
  );
endinterface
`default_nettype wire

// File: rtl/spi_cfg_hub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_cfg_hub
// Purpose  : SPI mode-0 slave that exposes a bank of NUM_CFG configuration
//            registers (single or auto-increment burst access, per-register
//            write strobes) and a sequential status + capture-memory read
//            stream. Illegal accesses fall into a silent discard state.
// Ports    : clk, rst_n   - system clock, async active-low reset
//            spi          - SPI pins (slave modport), asynchronous to clk
//            cfg_out      - register k at [k*CFG_W +: CFG_W]
//            cfg_wr       - one-clk write strobe per register
//            status_in    - 16-bit status word streamed before memory data
//            mem_addr     - capture-memory read address
//            mem_data     - capture-memory read data (1 clk after mem_addr)
//            spi_busy     - synchronised chip select is low
// Revision : 1.0 - initial release
// ============================================================================
module spi_cfg_hub #(
  parameter int         NUM_CFG = 4,
  parameter int         CFG_W   = 32,
  parameter int         MEM_AW  = 11,
  parameter int         MEM_DW  = 16,
  parameter logic [7:0] DEV_ID  = 8'h91
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  spi_cfg_hub_if.slave                    spi,
  output logic [NUM_CFG*CFG_W-1:0]        cfg_out,
  output logic [NUM_CFG-1:0]              cfg_wr,
  input  wire logic [15:0]                status_in,
  output logic [MEM_AW-1:0]               mem_addr,
  input  wire logic [MEM_DW-1:0]          mem_data,
  output logic                            spi_busy
);

  // Transmit shifter is wide enough for the longest word; loads are left-justified.
  localparam int c_TX_W0  = (CFG_W > 16) ? CFG_W : 16;
  localparam int c_TX_W   = (c_TX_W0 > MEM_DW) ? c_TX_W0 : MEM_DW;
  localparam int c_CNT_W  = $clog2(c_TX_W) + 1;
  localparam int c_IDX_W  = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;

  localparam logic [c_CNT_W-1:0] c_LAST_CMD = c_CNT_W'(7);
  localparam logic [c_CNT_W-1:0] c_LAST_CFG = c_CNT_W'(CFG_W - 1);
  localparam logic [c_CNT_W-1:0] c_LAST_STS = c_CNT_W'(15);
  localparam logic [c_CNT_W-1:0] c_LAST_MEM = c_CNT_W'(MEM_DW - 1);
  localparam logic [4:0]         c_NCFG     = 5'(NUM_CFG);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_CFG     = 3'd2,
    S_STATUS  = 3'd3,
    S_MEM     = 3'd4,
    S_DISCARD = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronisers and registered edge pulses
  // --------------------------------------------------------------------------
  logic [1:0] r_ncs_s;
  logic       r_ncs_d;
  logic       r_ncs_fall;
  logic       r_ncs_rise;
  logic [1:0] r_vld;
  logic       r_armed;
  logic [1:0] r_sck_s;
  logic       r_sck_d;
  logic       r_sck_rise;
  logic       r_sck_fall;
  logic [1:0] r_mosi_s;
  logic       r_busy;

  // The ncs chain resets to "deselected". r_armed only allows an ncs-fall
  // once a genuine post-reset high has been seen, so a reset released while
  // the master still holds ncs low does not start a bogus transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ncs_s    <= 2'b11;
      r_ncs_d    <= 1'b1;
      r_ncs_fall <= 1'b0;
      r_ncs_rise <= 1'b0;
      r_vld      <= 2'b00;
      r_armed    <= 1'b0;
      r_sck_s    <= 2'b00;
      r_sck_d    <= 1'b0;
      r_sck_rise <= 1'b0;
      r_sck_fall <= 1'b0;
      r_mosi_s   <= 2'b00;
      r_busy     <= 1'b0;
    end else begin
      r_ncs_s    <= {r_ncs_s[0], spi.ncs_spi};
      r_ncs_d    <= r_ncs_s[1];
      r_ncs_fall <= r_armed & r_ncs_d & ~r_ncs_s[1];
      r_ncs_rise <= ~r_ncs_d & r_ncs_s[1];
      r_vld      <= {r_vld[0], 1'b1};
      r_armed    <= r_armed | (r_vld[1] & r_ncs_s[1]);
      r_sck_s    <= {r_sck_s[0], spi.sck_spi};
      r_sck_d    <= r_sck_s[1];
      r_sck_rise <= ~r_sck_d & r_sck_s[1];
      r_sck_fall <= r_sck_d & ~r_sck_s[1];
      r_mosi_s   <= {r_mosi_s[0], spi.mosi_spi};
      r_busy     <= ~r_ncs_d;
    end
  end

  // --------------------------------------------------------------------------
  // Protocol FSM
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [c_TX_W-1:0]    r_tx;
  logic [CFG_W-1:0]     r_rx;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_hold;
  logic                 r_wr;
  logic                 r_burst;
  logic [3:0]           r_addr;
  logic [CFG_W-1:0]     r_cfg [NUM_CFG];
  logic [NUM_CFG-1:0]   r_cfg_wr;
  logic [MEM_AW-1:0]    r_mem_addr;

  logic                 w_mosi;
  logic [7:0]           w_cmd;
  logic [CFG_W-1:0]     w_word;
  logic [c_IDX_W-1:0]   w_cmd_idx;
  logic [c_IDX_W-1:0]   w_idx;
  logic [c_IDX_W-1:0]   w_idx_nxt;
  logic                 w_next_ok;
  logic                 w_drive;

  assign w_mosi    = r_mosi_s[1];
  // Received word including the bit arriving with the current sck-rise pulse.
  assign w_cmd     = {r_rx[6:0], w_mosi};
  assign w_word    = {r_rx[CFG_W-2:0], w_mosi};
  assign w_cmd_idx = w_cmd[c_IDX_W-1:0];
  assign w_idx     = r_addr[c_IDX_W-1:0];
  assign w_idx_nxt = w_idx + c_IDX_W'(1);
  assign w_next_ok = (5'(r_addr) + 5'd1) < c_NCFG;

  // r_hold: a word was just loaded on an sck-rise, so the following sck-fall
  // must present that MSB rather than shift it away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tx       <= '0;
      r_rx       <= '0;
      r_cnt      <= '0;
      r_hold     <= 1'b0;
      r_wr       <= 1'b0;
      r_burst    <= 1'b0;
      r_addr     <= '0;
      r_cfg_wr   <= '0;
      r_mem_addr <= '0;
      for (int k = 0; k < NUM_CFG; k++) r_cfg[k] <= '0;
    end else begin
      r_cfg_wr <= '0;
      if (r_ncs_rise) begin
        // Any partial word is simply dropped; mem_addr keeps its value.
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_hold  <= 1'b0;
      end else if (r_state == S_IDLE) begin
        if (r_ncs_fall) begin
          r_tx    <= c_TX_W'(DEV_ID) << (c_TX_W - 8);
          r_cnt   <= '0;
          r_hold  <= 1'b0;
          r_state <= S_CMD;
        end
      end else if (r_sck_fall) begin
        if (r_hold) r_hold <= 1'b0;
        else        r_tx   <= {r_tx[c_TX_W-2:0], 1'b0};
      end else if (r_sck_rise) begin
        r_rx  <= w_word;
        r_cnt <= r_cnt + c_CNT_W'(1);
        case (r_state)
          S_CMD: begin
            if (r_cnt == c_LAST_CMD) begin
              r_cnt   <= '0;
              r_wr    <= w_cmd[7];
              r_burst <= w_cmd[6];
              r_addr  <= w_cmd[3:0];
              if ({1'b0, w_cmd[3:0]} < c_NCFG) begin
                r_tx    <= c_TX_W'(r_cfg[w_cmd_idx]) << (c_TX_W - CFG_W);
                r_hold  <= 1'b1;
                r_state <= S_CFG;
              end else if (w_cmd[3:0] == 4'hF) begin
                r_tx       <= c_TX_W'(status_in) << (c_TX_W - 16);
                r_hold     <= 1'b1;
                r_mem_addr <= '0;
                r_state    <= S_STATUS;
              end else begin
                r_state <= S_DISCARD;
              end
            end
          end
          S_CFG: begin
            if (r_cnt == c_LAST_CFG) begin
              r_cnt <= '0;
              if (r_wr) begin
                r_cfg[w_idx]    <= w_word;
                r_cfg_wr[w_idx] <= 1'b1;
              end
              if (r_burst && w_next_ok) begin
                r_addr <= r_addr + 4'd1;
                r_tx   <= c_TX_W'(r_cfg[w_idx_nxt]) << (c_TX_W - CFG_W);
                r_hold <= 1'b1;
              end else begin
                r_state <= S_DISCARD;
              end
            end
          end
          S_STATUS: begin
            if (r_cnt == c_LAST_STS) begin
              r_cnt      <= '0;
              r_tx       <= c_TX_W'(mem_data) << (c_TX_W - MEM_DW);
              r_hold     <= 1'b1;
              r_mem_addr <= r_mem_addr + MEM_AW'(1);
              r_state    <= S_MEM;
            end
          end
          S_MEM: begin
            // mem_data has been stable for a whole word since the last
            // address step, so the RAM latency is always covered.
            if (r_cnt == c_LAST_MEM) begin
              r_cnt      <= '0;
              r_tx       <= c_TX_W'(mem_data) << (c_TX_W - MEM_DW);
              r_hold     <= 1'b1;
              r_mem_addr <= r_mem_addr + MEM_AW'(1);
            end
          end
          default: ;  // DISCARD: wait for ncs-rise
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign w_drive = ((r_state == S_CMD) || (r_state == S_CFG) ||
                    (r_state == S_STATUS) || (r_state == S_MEM)) && !r_ncs_s[1];

  assign spi.miso_spi = w_drive & r_tx[c_TX_W-1];
  assign cfg_wr       = r_cfg_wr;
  assign mem_addr     = r_mem_addr;
  assign spi_busy     = r_busy;

  generate
    for (genvar k = 0; k < NUM_CFG; k++) begin : g_pack
      assign cfg_out[k*CFG_W +: CFG_W] = r_cfg[k];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_hub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_cfg_hub
// Purpose  : Directed self-checking bench for spi_cfg_hub (default params).
//            Acts as a mode-0 SPI master with sck half-period of 8 clk and
//            models the capture memory as word n = n with 1-clk latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cfg_hub;

  localparam int HALF = 80;  // ns, 8 clk periods

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] cfg_out;
  logic [3:0]   cfg_wr;
  logic [15:0]  status_in;
  logic [10:0]  mem_addr;
  logic [15:0]  mem_data;
  logic         spi_busy;

  int errors = 0;
  int checks = 0;
  int sc [4] = '{0, 0, 0, 0};

  logic [31:0] rd;

  spi_cfg_hub_if spi_bus ();

  spi_cfg_hub dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi_bus.slave),
    .cfg_out   (cfg_out),
    .cfg_wr    (cfg_wr),
    .status_in (status_in),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .spi_busy  (spi_busy)
  );

  always #5 clk = ~clk;

  // Capture memory: word n holds n, one clk read latency.
  always @(posedge clk) mem_data <= 16'(mem_addr);

  // Count clk cycles each strobe is high.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) if (cfg_wr[k]) sc[k] = sc[k] + 1;
  end

  function automatic logic [31:0] cfg_reg(input int k);
    return cfg_out[k*32 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cs_on();
    spi_bus.ncs_spi = 1'b0;
  endtask

  task automatic cs_off();
    #HALF;
    spi_bus.ncs_spi = 1'b1;
    #(2*HALF);
  endtask

  // Shift n bits MSB first; miso is sampled just before each sck rise.
  task automatic xfer(input int n, input logic [31:0] dout, output logic [31:0] din);
    din = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bus.mosi_spi = dout[i];
      #HALF;
      din[i] = spi_bus.miso_spi;
      spi_bus.sck_spi = 1'b1;
      #HALF;
      spi_bus.sck_spi = 1'b0;
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    spi_bus.ncs_spi  = 1'b1;
    spi_bus.sck_spi  = 1'b0;
    spi_bus.mosi_spi = 1'b0;
    status_in        = 16'h0000;
    #100;

    // Reset state
    chk("rst_cfg_out", 64'(cfg_out == '0), 64'd1);
    chk("rst_cfg_wr",  64'(cfg_wr), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_miso", 64'(spi_bus.miso_spi), 64'h0);
    chk("rst_busy", 64'(spi_busy), 64'h0);
    rst_n = 1'b1;
    #200;

    // Identification read of register 0
    cs_on();
    xfer(8, 32'h00, rd);
    chk("id_byte", 64'(rd[7:0]), 64'h91);
    chk("busy_active", 64'(spi_busy), 64'h1);
    xfer(32, 32'h0, rd);
    chk("id_reg0", 64'(rd), 64'h0);
    cs_off();
    chk("busy_idle", 64'(spi_busy), 64'h0);

    // Single write to register 2
    cs_on();
    xfer(8, 32'h82, rd);
    chk("wr_id_byte", 64'(rd[7:0]), 64'h91);
    xfer(32, 32'hDEADBEEF, rd);
    chk("wr_old_reg2", 64'(rd), 64'h0);
    cs_off();
    chk("wr_reg2", 64'(cfg_reg(2)), 64'hDEADBEEF);
    chk("wr_reg0", 64'(cfg_reg(0)), 64'h0);
    chk("wr_reg1", 64'(cfg_reg(1)), 64'h0);
    chk("wr_reg3", 64'(cfg_reg(3)), 64'h0);
    chk("wr_strobe2", 64'(sc[2]), 64'd1);
    chk("wr_strobe_other", 64'(sc[0] + sc[1] + sc[3]), 64'd0);

    // Burst write from register 2: third word runs past the bank
    cs_on();
    xfer(8, 32'hC2, rd);
    xfer(32, 32'hCAFEF00D, rd);
    chk("bw_snap2", 64'(rd), 64'hDEADBEEF);
    xfer(32, 32'h0BADF00D, rd);
    chk("bw_snap3", 64'(rd), 64'h0);
    xfer(32, 32'h11112222, rd);
    chk("bw_discard_miso", 64'(rd), 64'h0);
    cs_off();
    chk("bw_reg2", 64'(cfg_reg(2)), 64'hCAFEF00D);
    chk("bw_reg3", 64'(cfg_reg(3)), 64'h0BADF00D);
    chk("bw_reg0", 64'(cfg_reg(0)), 64'h0);
    chk("bw_reg1", 64'(cfg_reg(1)), 64'h0);
    chk("bw_strobe2", 64'(sc[2]), 64'd2);
    chk("bw_strobe3", 64'(sc[3]), 64'd1);

    // Write register 1, then abort a second write after 20 bits
    cs_on();
    xfer(8, 32'h81, rd);
    xfer(32, 32'h12345678, rd);
    cs_off();
    chk("pa_setup_reg1", 64'(cfg_reg(1)), 64'h12345678);
    chk("pa_setup_strobe1", 64'(sc[1]), 64'd1);
    cs_on();
    xfer(8, 32'h81, rd);
    xfer(20, 32'hFFFFF, rd);
    cs_off();
    chk("pa_reg1_kept", 64'(cfg_reg(1)), 64'h12345678);
    chk("pa_no_strobe", 64'(sc[1]), 64'd1);
    cs_on();
    xfer(8, 32'h01, rd);
    xfer(32, 32'h0, rd);
    cs_off();
    chk("pa_readback", 64'(rd), 64'h12345678);

    // Status + memory stream
    status_in = 16'h0ABC;
    cs_on();
    xfer(8, 32'h0F, rd);
    chk("ms_id_byte", 64'(rd[7:0]), 64'h91);
    xfer(16, 32'h0, rd);
    chk("ms_status", 64'(rd[15:0]), 64'h0ABC);
    for (int n = 0; n < 3; n++) begin
      xfer(16, 32'h0, rd);
      chk($sformatf("ms_word%0d", n), 64'(rd[15:0]), 64'(n));
    end
    chk("ms_addr_after3", 64'(mem_addr), 64'd4);
    xfer(16, 32'h0, rd);
    chk("ms_word3", 64'(rd[15:0]), 64'd3);
    cs_off();
    // One address step per completed word, status word included.
    chk("ms_addr_end", 64'(mem_addr), 64'd5);

    // Illegal address
    cs_on();
    xfer(8, 32'h87, rd);
    chk("il_id_byte", 64'(rd[7:0]), 64'h91);
    xfer(32, 32'hFFFFFFFF, rd);
    chk("il_miso", 64'(rd), 64'h0);
    cs_off();
    chk("il_no_strobe", 64'(sc[0] + sc[1] + sc[2] + sc[3]), 64'd4);
    chk("il_reg1", 64'(cfg_reg(1)), 64'h12345678);
    chk("il_reg3", 64'(cfg_reg(3)), 64'h0BADF00D);

    // Reset in the middle of a CFG word
    cs_on();
    xfer(8, 32'h82, rd);
    xfer(12, 32'h0, rd);
    #HALF;
    // 12 shifts of CAFEF00D leave bit 19 (=1) on miso
    chk("mr_miso_before", 64'(spi_bus.miso_spi), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_cfg_cleared", 64'(cfg_out == '0), 64'd1);
    chk("mr_miso", 64'(spi_bus.miso_spi), 64'h0);
    chk("mr_mem_addr", 64'(mem_addr), 64'h0);
    #99;
    rst_n = 1'b1;
    #200;
    chk("mr_idle_miso", 64'(spi_bus.miso_spi), 64'h0);
    chk("mr_idle_cfg", 64'(cfg_out == '0), 64'd1);
    spi_bus.ncs_spi = 1'b1;
    #(2*HALF);
    cs_on();
    xfer(8, 32'h02, rd);
    chk("mr_id_byte", 64'(rd[7:0]), 64'h91);
    xfer(32, 32'h0, rd);
    chk("mr_reg2_read", 64'(rd), 64'h0);
    cs_off();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
